// File: rtl/cam_pkg.sv
// Shared types and helpers for the camera capture path.
// RGB565 to RGB332 reduction and capture FSM states.
package cam_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        WAIT_SOF,
        CAPTURE,
        DONE
    } cap_state_t;

    localparam int H_ACTIVE_DEF = 160;
    localparam int V_ACTIVE_DEF = 120;
    localparam int FRAME_PIX    = H_ACTIVE_DEF * V_ACTIVE_DEF;

    // Keep the top bits of each colour channel.
    function automatic logic [7:0] rgb565_to_rgb332(input logic [15:0] px);
        return {3'(px[15:11] >> 2), 3'(px[10:5] >> 3), 2'(px[4:0] >> 3)};
    endfunction

endpackage

// File: rtl/cam_sync.sv
// Camera bus synchronizer: 2-FF sync plus one history stage,
// with edge detectors on pclk, vsync and href.
module cam_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic       cam_pclk,
    input  logic       cam_vsync,
    input  logic       cam_href,
    input  logic [7:0] cam_data,
    output logic       pclk_rise,
    output logic       vsync_rise,
    output logic       vsync_fall,
    output logic       href_s,
    output logic       href_fall,
    output logic [7:0] data_s
);

    logic [10:0] raw;
    logic [10:0] s1;
    logic [10:0] s2;
    logic [10:0] s3;

    assign raw = {cam_data, cam_href, cam_vsync, cam_pclk};

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign pclk_rise  = s2[0] & ~s3[0];
    assign vsync_rise = s2[1] & ~s3[1];
    assign vsync_fall = ~s2[1] & s3[1];
    assign href_s     = s2[2];
    assign href_fall  = ~s2[2] & s3[2];
    // Sampled just ahead of the pclk edge, where the camera holds data stable.
    assign data_s     = s3[10:3];

endmodule

// File: rtl/cam_pixel_capture.sv
// Single-frame camera capture: RGB565 byte pairs to RGB332
// sequential frame-buffer writes, with busy/done/error status.
module cam_pixel_capture
    import cam_pkg::*;
#(
    parameter int H_ACTIVE = 160,
    parameter int V_ACTIVE = 120,
    parameter int ADDR_W   = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              cam_pclk,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [7:0]        cam_data,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [7:0]        wr_data_o
);

    localparam int COL_W  = $clog2(H_ACTIVE + 1);
    localparam int LINE_W = $clog2(V_ACTIVE + 1);

    localparam logic [COL_W-1:0]  COL_END  = COL_W'(H_ACTIVE);
    localparam logic [LINE_W-1:0] LINE_END = LINE_W'(V_ACTIVE);
    // One extra bit so a frame filling the whole RAM still has a limit.
    localparam logic [ADDR_W:0]   FRAME_N  = (ADDR_W + 1)'(H_ACTIVE * V_ACTIVE);

    logic       pclk_rise;
    logic       vsync_rise;
    logic       vsync_fall;
    logic       href_s;
    logic       href_fall;
    logic [7:0] data_s;

    cap_state_t        state;
    logic [COL_W-1:0]  col;
    logic [LINE_W-1:0] line;
    logic [ADDR_W:0]   addr;
    logic              phase;
    logic [7:0]        hi;

    cam_sync u_sync (
        .clk        (clk),
        .rst        (rst),
        .cam_pclk   (cam_pclk),
        .cam_vsync  (cam_vsync),
        .cam_href   (cam_href),
        .cam_data   (cam_data),
        .pclk_rise  (pclk_rise),
        .vsync_rise (vsync_rise),
        .vsync_fall (vsync_fall),
        .href_s     (href_s),
        .href_fall  (href_fall),
        .data_s     (data_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            col       <= '0;
            line      <= '0;
            addr      <= '0;
            phase     <= 1'b0;
            hi        <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            err_o     <= 1'b0;
            wr_en_o   <= 1'b0;
            wr_addr_o <= '0;
            wr_data_o <= '0;
        end else begin
            wr_en_o <= 1'b0;
            done_o  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start_i) begin
                        err_o  <= 1'b0;
                        busy_o <= 1'b1;
                        state  <= ARM;
                    end
                end
                ARM: begin
                    if (vsync_rise) state <= WAIT_SOF;
                end
                WAIT_SOF: begin
                    if (vsync_fall) begin
                        col   <= '0;
                        line  <= '0;
                        addr  <= '0;
                        phase <= 1'b0;
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (vsync_rise) begin
                        if (line < LINE_END) err_o <= 1'b1;
                        done_o <= 1'b1;
                        busy_o <= 1'b0;
                        state  <= DONE;
                    end else if (href_fall) begin
                        if (col != COL_END || phase) err_o <= 1'b1;
                        if (line == LINE_END) err_o <= 1'b1;
                        else line <= line + 1'b1;
                        col   <= '0;
                        phase <= 1'b0;
                    end else if (pclk_rise && href_s) begin
                        if (!phase) begin
                            hi    <= data_s;
                            phase <= 1'b1;
                        end else begin
                            phase <= 1'b0;
                            if (addr < FRAME_N) begin
                                wr_en_o   <= 1'b1;
                                wr_addr_o <= addr[ADDR_W-1:0];
                                wr_data_o <= rgb565_to_rgb332({hi, data_s});
                                addr      <= addr + 1'b1;
                                if (col != COL_END) col <= col + 1'b1;
                            end else begin
                                err_o <= 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cam_pixel_capture.sv
// Directed-random bench for cam_pixel_capture against a frame-level
// reference model of the expected RAM writes and status.
module tb_cam_pixel_capture;

    localparam int H  = 4;
    localparam int V  = 2;
    localparam int AW = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_i = 1'b0;
    logic          cam_pclk = 1'b0;
    logic          cam_vsync = 1'b0;
    logic          cam_href = 1'b0;
    logic [7:0]    cam_data = 8'h00;
    logic          busy_o;
    logic          done_o;
    logic          err_o;
    logic          wr_en_o;
    logic [AW-1:0] wr_addr_o;
    logic [7:0]    wr_data_o;

    always #5 clk = ~clk;

    cam_pixel_capture #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .ADDR_W   (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .cam_pclk  (cam_pclk),
        .cam_vsync (cam_vsync),
        .cam_href  (cam_href),
        .cam_data  (cam_data),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .err_o     (err_o),
        .wr_en_o   (wr_en_o),
        .wr_addr_o (wr_addr_o),
        .wr_data_o (wr_data_o)
    );

    int nvec = 0;
    int nerr = 0;

    int  wq_addr[$];
    int  wq_data[$];
    int  done_cnt = 0;
    int  done_base = 0;
    time t_wr_first = 0;
    time t_pc2 = 0;

    always @(negedge clk) begin
        if (wr_en_o === 1'b1) begin
            if (wq_addr.size() == 0) t_wr_first = $time;
            wq_addr.push_back(int'(wr_addr_o));
            wq_data.push_back(int'(wr_data_o));
        end
        if (done_o === 1'b1) done_cnt++;
    end

    int         exp_addr[$];
    int         exp_data[$];
    bit         exp_err;
    int         m_line;
    int         m_pix;
    logic [7:0] lb [0:63];

    function automatic int rgb(input int hi, input int lo);
        int r5, g6, b5;
        r5 = hi >> 3;
        g6 = ((hi & 7) << 3) | (lo >> 5);
        b5 = lo & 31;
        return ((r5 >> 2) << 5) | ((g6 >> 3) << 2) | (b5 >> 3);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        nvec++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        exp_addr.delete();
        exp_data.delete();
        exp_err = 1'b0;
        m_line  = 0;
        m_pix   = 0;
    endtask

    task automatic model_line(input int nb);
        for (int p = 0; p < nb / 2; p++) begin
            if (m_pix < H * V) begin
                exp_addr.push_back(m_pix);
                exp_data.push_back(rgb(int'(lb[2*p]), int'(lb[2*p+1])));
                m_pix++;
            end else begin
                exp_err = 1'b1;
            end
        end
        if (nb != 2 * H) exp_err = 1'b1;
        if (m_line >= V) exp_err = 1'b1;
        m_line++;
    endtask

    task automatic model_end();
        if (m_line < V) exp_err = 1'b1;
    endtask

    task automatic clear_obs();
        wq_addr.delete();
        wq_data.delete();
        done_base = done_cnt;
    endtask

    task automatic cam_byte(input logic [7:0] b, input bit mark);
        cam_data = b;
        #40;
        cam_pclk = 1'b1;
        if (mark) t_pc2 = $time;
        #40;
        cam_pclk = 1'b0;
    endtask

    task automatic send_line(input int nb, input bit capt, input bit force_first);
        for (int i = 0; i < nb; i++) lb[i] = 8'($urandom_range(0, 255));
        if (force_first) begin
            lb[0] = 8'hF8;
            lb[1] = 8'h1F;
        end
        cam_href = 1'b1;
        for (int i = 0; i < nb; i++) cam_byte(lb[i], force_first && i == 1);
        cam_href = 1'b0;
        #80;
        if (capt) model_line(nb);
    endtask

    task automatic vsync_pulse();
        cam_vsync = 1'b1;
        #100;
        cam_vsync = 1'b0;
        #100;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        #10;
        start_i = 1'b0;
    endtask

    task automatic check_frame(input string tag);
        int n;
        chk({tag, "_nwr"}, 32'(wq_addr.size()), 32'(exp_addr.size()));
        n = (wq_addr.size() < exp_addr.size()) ? wq_addr.size() : exp_addr.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_addr"}, 32'(wq_addr[i]), 32'(exp_addr[i]));
            chk({tag, "_data"}, 32'(wq_data[i]), 32'(exp_data[i]));
        end
        chk({tag, "_err"}, 32'(err_o), 32'(exp_err));
        chk({tag, "_done"}, 32'(done_cnt - done_base), 32'd1);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
        chk({tag, "_done"}, 32'(done_o), 32'd0);
        chk({tag, "_err"}, 32'(err_o), 32'd0);
        chk({tag, "_wren"}, 32'(wr_en_o), 32'd0);
        chk({tag, "_waddr"}, 32'(wr_addr_o), 32'd0);
        chk({tag, "_wdata"}, 32'(wr_data_o), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        #30;
        chk_zero("rst");
        rst = 1'b0;
        #20;

        // nominal frame with ignored extra starts
        model_reset();
        clear_obs();
        pulse_start();
        chk("nom_busy", 32'(busy_o), 32'd1);
        chk("nom_errclr", 32'(err_o), 32'd0);
        pulse_start();
        vsync_pulse();
        send_line(8, 1'b1, 1'b1);
        pulse_start();
        send_line(8, 1'b1, 1'b0);
        model_end();
        vsync_pulse();
        check_frame("nom");
        chk("nom_first", 32'(wq_data.size() > 0 ? wq_data[0] : -1), 32'h0E3);
        chk("nom_lat", 32'((t_wr_first >= t_pc2) && (t_wr_first - t_pc2 <= 40)), 32'd1);

        // start arrives mid-frame; only the following frame is captured
        model_reset();
        clear_obs();
        vsync_pulse();
        send_line(8, 1'b0, 1'b0);
        pulse_start();
        send_line(8, 1'b0, 1'b0);
        chk("arm_nowr", 32'(wq_addr.size()), 32'd0);
        vsync_pulse();
        send_line(8, 1'b1, 1'b0);
        send_line(8, 1'b1, 1'b0);
        model_end();
        vsync_pulse();
        check_frame("arm");

        // short first line
        model_reset();
        clear_obs();
        pulse_start();
        vsync_pulse();
        send_line(6, 1'b1, 1'b0);
        chk("short_err_early", 32'(err_o), 32'd1);
        send_line(8, 1'b1, 1'b0);
        model_end();
        vsync_pulse();
        check_frame("short");

        // one line too many
        model_reset();
        clear_obs();
        pulse_start();
        chk("ovf_errclr", 32'(err_o), 32'd0);
        vsync_pulse();
        send_line(8, 1'b1, 1'b0);
        send_line(8, 1'b1, 1'b0);
        send_line(8, 1'b1, 1'b0);
        model_end();
        vsync_pulse();
        check_frame("ovf");

        // reset lands between second-byte detection and its write
        clear_obs();
        pulse_start();
        vsync_pulse();
        cam_href = 1'b1;
        cam_byte(8'h12, 1'b0);
        cam_data = 8'h34;
        #40;
        cam_pclk = 1'b1;
        #20;
        rst = 1'b1;
        #10;
        chk_zero("mrst");
        rst = 1'b0;
        #10;
        cam_pclk = 1'b0;
        cam_href = 1'b0;
        #200;
        chk("mrst_nowr", 32'(wq_addr.size()), 32'd0);
        chk("mrst_nodone", 32'(done_cnt - done_base), 32'd0);
        vsync_pulse();
        send_line(8, 1'b0, 1'b0);
        send_line(8, 1'b0, 1'b0);
        vsync_pulse();
        chk("mrst_idle_nowr", 32'(wq_addr.size()), 32'd0);
        chk("mrst_idle_busy", 32'(busy_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
